// File: rtl/bitmap_blit_ctrl.sv
// bitmap_blit_ctrl: copies one 16x16 glyph from the bitmap ROM into the framebuffer.
// Each of the 256 ROM addresses is walked in row-major order. One (x, y, pixel)
// write beat is produced per pixel over a valid/ready handshake.
// Optional feature macro: BITMAP_BLIT_TRANSPARENT_EN. When it is defined, 8'h00
// pixels are skipped rather than emitted.
module bitmap_blit_ctrl #(
    parameter int ADDRBITS = 9,
    parameter int XBITS    = 10,
    parameter int YBITS    = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDRBITS-9:0]   glyph,
    input  logic [XBITS-1:0]      x0,
    input  logic [YBITS-1:0]      y0,
    output logic                  busy,
    output logic                  done,
    output logic [ADDRBITS-1:0]   rom_addr,
    input  logic [7:0]            rom_pixel,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [XBITS-1:0]      wr_x,
    output logic [YBITS-1:0]      wr_y,
    output logic [7:0]            wr_pixel
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]          state_reg;
    logic [ADDRBITS-9:0] glyph_reg;
    logic [XBITS-1:0]    x0_reg;
    logic [YBITS-1:0]    y0_reg;
    logic [3:0]          row_reg;
    logic [3:0]          col_reg;

    logic slot_free;
    logic fetch;
    logic skip;
    logic last_pix;

    // The output slot can take a new beat when it is empty or is being drained this cycle.
    assign slot_free = !wr_valid || wr_ready;
    assign fetch     = (state_reg == S_RUN) && slot_free;
    assign last_pix  = (row_reg == 4'hF) && (col_reg == 4'hF);
    assign busy      = (state_reg != S_IDLE);
    assign rom_addr  = {glyph_reg, row_reg, col_reg};

`ifdef BITMAP_BLIT_TRANSPARENT_EN
    assign skip = (rom_pixel == 8'h00);
`else
    assign skip = 1'b0;
`endif

    // Sequencer FSM: request capture, row-major pixel walk, final drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            glyph_reg <= '0;
            x0_reg    <= '0;
            y0_reg    <= '0;
            row_reg   <= 4'd0;
            col_reg   <= 4'd0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        glyph_reg <= glyph;
                        x0_reg    <= x0;
                        y0_reg    <= y0;
                        row_reg   <= 4'd0;
                        col_reg   <= 4'd0;
                        state_reg <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (slot_free) begin
                        col_reg <= col_reg + 4'd1;
                        if (col_reg == 4'hF) begin
                            row_reg <= row_reg + 4'd1;
                        end
                        if (last_pix) begin
                            state_reg <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (slot_free) begin
                        state_reg <= S_IDLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // Output beat register.
    // A fetch loads a new beat; a skipped fetch or an accepted beat with no refill empties the slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_valid <= 1'b0;
            wr_x     <= '0;
            wr_y     <= '0;
            wr_pixel <= 8'h00;
        end else if (fetch) begin
            if (skip) begin
                wr_valid <= 1'b0;
            end else begin
                wr_valid <= 1'b1;
                wr_pixel <= rom_pixel;
                wr_x     <= x0_reg + XBITS'(col_reg);
                wr_y     <= y0_reg + YBITS'(row_reg);
            end
        end else if (wr_ready) begin
            wr_valid <= 1'b0;
        end
    end

    // Single-cycle completion pulse, raised on the cycle that follows the drain exit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done <= 1'b0;
        end else begin
            done <= (state_reg == S_DRAIN) && slot_free;
        end
    end

endmodule

// File: tb/tb_bitmap_blit_ctrl.sv
// Testbench for bitmap_blit_ctrl: table-driven glyph runs plus hand-written
// sequences for ignored/chained starts and mid-run reset.
module tb_bitmap_blit_ctrl;

    localparam int ADDRBITS = 9;
    localparam int XBITS    = 10;
    localparam int YBITS    = 10;
`ifdef BITMAP_BLIT_TRANSPARENT_EN
    localparam bit TRANSP = 1'b1;
`else
    localparam bit TRANSP = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic [ADDRBITS-9:0] glyph;
    logic [XBITS-1:0]    x0;
    logic [YBITS-1:0]    y0;
    logic                busy;
    logic                done;
    logic [ADDRBITS-1:0] rom_addr;
    logic [7:0]          rom_pixel;
    logic                wr_valid;
    logic                wr_ready;
    logic [XBITS-1:0]    wr_x;
    logic [YBITS-1:0]    wr_y;
    logic [7:0]          wr_pixel;

    logic [7:0] rom [0:511];
    assign rom_pixel = rom[rom_addr];

    always #5 clk = ~clk;

    bitmap_blit_ctrl #(.ADDRBITS(ADDRBITS), .XBITS(XBITS), .YBITS(YBITS)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .glyph(glyph), .x0(x0), .y0(y0),
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_pixel(rom_pixel),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_x(wr_x), .wr_y(wr_y),
        .wr_pixel(wr_pixel)
    );

    typedef struct {
        int          glyph;
        int          x0;
        int          y0;
        int          mode;      // 0: ready always 1, 1: ready = cycle index odd
        int          rom_mode;  // 0: standard, 1: glyph1 has 200 nonzero, 2: glyph1 all zero
        int          n_beats;
        int          done_cyc;
        int          mid_idx;
        logic [27:0] first;
        logic [27:0] mid;
        logic [27:0] last;
    } vec_t;

    vec_t vecs [0:5];
    int n_cmp = 0;
    int n_err = 0;
    bit pre_started = 1'b0;
    logic [27:0] got [$];
    logic [27:0] expq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Glyph 0 is always ROM[i]=i+1; glyph 1 depends on the mode.
    task automatic load_rom(input int mode);
        int k;
        for (int i = 0; i < 512; i++) begin
            k = i % 256;
            if (i < 256)        rom[i] = 8'(k + 1);
            else if (mode == 1) rom[i] = (k < 200) ? 8'(k + 1) : 8'h00;
            else if (mode == 2) rom[i] = 8'h00;
            else                rom[i] = 8'(k) ^ 8'hA5;
        end
    endtask

    task automatic run_glyph(input vec_t v, input string tag, input int poke_cyc,
                             input bit chain, input vec_t nv);
        int done_c;
        int first_v;
        int busy_err;
        int hold_err;
        int seq_err;
        bit prev_v;
        bit prev_r;
        bit rdy;
        logic [27:0] prev_b;
        logic [27:0] cur;
        logic [7:0] pix;
        done_c = 0; first_v = 0; busy_err = 0; hold_err = 0; seq_err = 0;
        prev_v = 1'b0; prev_r = 1'b0; prev_b = '0;
        load_rom(v.rom_mode);
        expq.delete();
        got.delete();
        for (int k = 0; k < 256; k++) begin
            pix = rom[v.glyph * 256 + k];
            if (!(TRANSP && pix == 8'h00))
                expq.push_back({10'(v.x0 + k % 16), 10'(v.y0 + k / 16), pix});
        end
        if (!pre_started) begin
            @(negedge clk);
            glyph = 1'(v.glyph); x0 = 10'(v.x0); y0 = 10'(v.y0); start = 1'b1;
        end
        pre_started = 1'b0;
        for (int c = 1; c <= 1200 && done_c == 0; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == poke_cyc) begin
                start = 1'b1; glyph = ~glyph; x0 = 10'd300; y0 = 10'd300;
            end
            cur = {wr_x, wr_y, wr_pixel};
            if (c == 1) begin
                chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
                chk({tag, "_no_done_c1"}, 32'(done), 32'd0);
            end
            if (wr_valid && first_v == 0) first_v = c;
            if (prev_v && !prev_r && (!wr_valid || cur !== prev_b)) hold_err++;
            rdy = (v.mode == 0) ? 1'b1 : c[0];
            wr_ready = rdy;
            if (wr_valid && rdy) got.push_back(cur);
            if (done) begin
                done_c = c;
                chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
                if (chain) begin
                    glyph = 1'(nv.glyph); x0 = 10'(nv.x0); y0 = 10'(nv.y0); start = 1'b1;
                    pre_started = 1'b1;
                end
            end else if (!busy) begin
                busy_err++;
            end
            prev_v = wr_valid; prev_r = rdy; prev_b = cur;
        end
        for (int i = 0; i < got.size() && i < expq.size(); i++)
            if (got[i] !== expq[i]) seq_err++;
        chk({tag, "_done_cycle"}, 32'(done_c), 32'(v.done_cyc));
        chk({tag, "_beat_count"}, 32'(got.size()), 32'(v.n_beats));
        chk({tag, "_model_count"}, 32'(got.size()), 32'(expq.size()));
        chk({tag, "_seq_errors"}, 32'(seq_err), 32'd0);
        chk({tag, "_hold_errors"}, 32'(hold_err), 32'd0);
        chk({tag, "_busy_errors"}, 32'(busy_err), 32'd0);
        chk({tag, "_first_valid_cyc"}, 32'(first_v), (v.n_beats > 0) ? 32'd2 : 32'd0);
        if (v.n_beats > 0 && got.size() > v.mid_idx) begin
            chk({tag, "_first_beat"}, 32'(got[0]), 32'(v.first));
            chk({tag, "_mid_beat"}, 32'(got[v.mid_idx]), 32'(v.mid));
            chk({tag, "_last_beat"}, 32'(got[got.size() - 1]), 32'(v.last));
        end
        $display("run %s: glyph=%0d origin=(%0d,%0d) beats=%0d done_cycle=%0d", tag,
                 v.glyph, v.x0, v.y0, got.size(), done_c);
    endtask

    task automatic reset_midrun();
        load_rom(0);
        @(negedge clk);
        glyph = 1'b0; x0 = 10'd100; y0 = 10'd50; start = 1'b1; wr_ready = 1'b1;
        for (int c = 1; c <= 102; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("rst_pre_valid", 32'(wr_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_valid", 32'(wr_valid), 32'd0);
        chk("rst_async_x", 32'(wr_x), 32'd0);
        chk("rst_async_y", 32'(wr_y), 32'd0);
        chk("rst_async_pixel", 32'(wr_pixel), 32'd0);
        chk("rst_async_addr", 32'(rom_addr), 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_hold_done", 32'(done), 32'd0);
            chk("rst_hold_valid", 32'(wr_valid), 32'd0);
        end
        rst_n = 1'b1;
        $display("reset mid-run at beat 100 applied and released");
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; glyph = 1'b0; x0 = '0; y0 = '0; wr_ready = 1'b0;
        load_rom(0);
        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_valid", 32'(wr_valid), 32'd0);
        chk("reset_x", 32'(wr_x), 32'd0);
        chk("reset_y", 32'(wr_y), 32'd0);
        chk("reset_pixel", 32'(wr_pixel), 32'd0);
        chk("reset_addr", 32'(rom_addr), 32'd0);
        rst_n = 1'b1;

`ifdef BITMAP_BLIT_TRANSPARENT_EN
        vecs[0] = '{0, 100, 50, 0, 0, 255, 258, 16, {10'd100, 10'd50, 8'h01},
                    {10'd100, 10'd51, 8'h11}, {10'd114, 10'd65, 8'hFF}};
        vecs[1] = '{1, 0, 0, 1, 0, 255, 512, 16, {10'd0, 10'd0, 8'hA5},
                    {10'd0, 10'd1, 8'hB5}, {10'd15, 10'd15, 8'h5A}};
        vecs[2] = '{0, 1020, 1020, 0, 0, 255, 258, 4, {10'd1020, 10'd1020, 8'h01},
                    {10'd0, 10'd1020, 8'h05}, {10'd10, 10'd11, 8'hFF}};
        vecs[3] = '{1, 5, 7, 0, 0, 255, 258, 165, {10'd5, 10'd7, 8'hA5},
                    {10'd11, 10'd17, 8'h03}, {10'd20, 10'd22, 8'h5A}};
        vecs[4] = '{1, 200, 100, 0, 1, 200, 258, 16, {10'd200, 10'd100, 8'h01},
                    {10'd200, 10'd101, 8'h11}, {10'd207, 10'd112, 8'hC8}};
        vecs[5] = '{1, 40, 30, 0, 2, 0, 258, 16, {10'd40, 10'd30, 8'h00},
                    {10'd40, 10'd31, 8'h00}, {10'd55, 10'd45, 8'h00}};
`else
        vecs[0] = '{0, 100, 50, 0, 0, 256, 258, 16, {10'd100, 10'd50, 8'h01},
                    {10'd100, 10'd51, 8'h11}, {10'd115, 10'd65, 8'h00}};
        vecs[1] = '{1, 0, 0, 1, 0, 256, 514, 16, {10'd0, 10'd0, 8'hA5},
                    {10'd0, 10'd1, 8'hB5}, {10'd15, 10'd15, 8'h5A}};
        vecs[2] = '{0, 1020, 1020, 0, 0, 256, 258, 4, {10'd1020, 10'd1020, 8'h01},
                    {10'd0, 10'd1020, 8'h05}, {10'd11, 10'd11, 8'h00}};
        vecs[3] = '{1, 5, 7, 0, 0, 256, 258, 165, {10'd5, 10'd7, 8'hA5},
                    {10'd10, 10'd17, 8'h00}, {10'd20, 10'd22, 8'h5A}};
        vecs[4] = '{1, 200, 100, 0, 1, 256, 258, 16, {10'd200, 10'd100, 8'h01},
                    {10'd200, 10'd101, 8'h11}, {10'd215, 10'd115, 8'h00}};
        vecs[5] = '{1, 40, 30, 0, 2, 256, 258, 16, {10'd40, 10'd30, 8'h00},
                    {10'd40, 10'd31, 8'h00}, {10'd55, 10'd45, 8'h00}};
`endif

        for (int i = 0; i < 6; i++) begin
            run_glyph(vecs[i], $sformatf("vec%0d", i), -1, 1'b0, vecs[i]);
        end

        // start during RUN is ignored; start on the done cycle launches the next glyph
        run_glyph(vecs[0], "ign_start", 50, 1'b1, vecs[3]);
        run_glyph(vecs[3], "chained", -1, 1'b0, vecs[3]);

        // reset mid-run, then a clean full run
        reset_midrun();
        run_glyph(vecs[0], "post_reset", -1, 1'b0, vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
